// File: rtl/tdc_measure_ctrl.sv
// Batch sequencer for the TDC delay line: clear, launch, settle, capture, accumulate popcount.
// Optional bubble check on captured codes is enabled by defining TDC_CTRL_BUBBLE_CHECK_EN.
module tdc_measure_ctrl #(
    parameter int N_DELAY       = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2,
    localparam int MW = $clog2(N_DELAY + 1),
    localparam int CW = MW + AVG_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               abort,
    input  logic [N_DELAY-1:0] tdc_code,
    output logic               tdc_clr,
    output logic               tdc_start,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CW-1:0]      res_count,
    output logic [MW-1:0]      res_mean,
    output logic               res_err,
    output logic [2:0]         dbg_state
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LAUNCH  = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] acc;
    logic [IW-1:0] sample_idx;
    logic [SW-1:0] settle_cnt;
    logic [MW-1:0] pop;

    assign dbg_state = state;
    assign res_count = acc;
    assign res_mean  = acc[CW-1:AVG_LOG2];

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            pop = pop + MW'(tdc_code[i]);
        end
    end

    // Result handshake: res_valid rises on entry to DONE and holds with a stable
    // res_count/res_mean/res_err until the edge where res_valid && res_ready; it is low from then on.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            sample_idx <= '0;
            settle_cnt <= '0;
            tdc_clr    <= 1'b0;
            tdc_start  <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else if (abort && state != IDLE && state != DONE) begin
            // Abort drops the line controls and discards any partial batch, including this capture.
            state      <= IDLE;
            acc        <= '0;
            sample_idx <= '0;
            tdc_clr    <= 1'b0;
            tdc_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !abort) begin
                        state      <= CLEAR;
                        acc        <= '0;
                        sample_idx <= '0;
                        tdc_clr    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= LAUNCH;
                    tdc_clr    <= 1'b0;
                    tdc_start  <= 1'b1;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                end
                LAUNCH: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= CAPTURE;
                        tdc_start <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                CAPTURE: begin
                    acc <= acc + CW'(pop);
                    if (sample_idx == LAST_IDX) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        state      <= CLEAR;
                        sample_idx <= sample_idx + IW'(1);
                        tdc_clr    <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tdc_clr   <= 1'b0;
                    tdc_start <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TDC_CTRL_BUBBLE_CHECK_EN
    logic err;
    logic code_ok;

    // A clean code is a run of ones from bit 0 (or all-zero): adding 1 carries through the whole run.
    assign code_ok = ((tdc_code & (tdc_code + N_DELAY'(1))) == '0);
    assign res_err = err;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err <= 1'b0;
        end else if (abort && state != IDLE && state != DONE) begin
            err <= 1'b0;
        end else if (state == IDLE && req && !abort) begin
            err <= 1'b0;
        end else if (state == CAPTURE && !code_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Directed bench for tdc_measure_ctrl with a result scoreboard fed at stimulus time.
module tb_tdc_measure_ctrl;

    localparam int CW = 8;
    localparam int MW = 6;
    localparam int RW = CW + MW + 1;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          abort;
    logic [31:0]   tdc_code;
    logic          tdc_clr;
    logic          tdc_start;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_count;
    logic [MW-1:0] res_mean;
    logic          res_err;
    logic [2:0]    dbg_state;

    logic [RW-1:0] exp_q[$];
    int            win_q[$];
    int            n_cmp;
    int            n_fail;
    int            run_len;
    int            overlap;
    int            lat;
    logic          seen_valid;

`ifdef TDC_CTRL_BUBBLE_CHECK_EN
    localparam logic BUBBLE_ERR = 1'b1;
`else
    localparam logic BUBBLE_ERR = 1'b0;
`endif

    tdc_measure_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .abort     (abort),
        .tdc_code  (tdc_code),
        .tdc_clr   (tdc_clr),
        .tdc_start (tdc_start),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_mean  (res_mean),
        .res_err   (res_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] pack(input int cnt, input int mean, input logic err);
        return {CW'(cnt), MW'(mean), err};
    endfunction

    // scoreboard monitor: a result leaves the DUT on every valid&&ready cycle
    always @(negedge clk) begin
        if (!rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got count=%0d mean=%0d err=%0b with no result expected",
                         res_count, res_mean, res_err);
            end else begin
                check("result", {res_count, res_mean, res_err}, 32'(exp_q.pop_front()));
            end
        end
    end

    // line-control observers
    always @(negedge clk) begin
        if (tdc_clr && tdc_start) overlap++;
        if (res_valid) seen_valid = 1'b1;
        if (tdc_start) begin
            run_len++;
        end else if (run_len != 0) begin
            win_q.push_back(run_len);
            run_len = 0;
        end
    end

    // driver: one batch, req pulsed; code switches to cr after the first capture
    task automatic run_batch(input logic [31:0] c0, input logic [31:0] cr, output int latency);
        int edges;
        tdc_code = c0;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        edges = 0;
        while (!res_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 7) tdc_code = cr;
        end
        latency = edges;
        if (!res_valid) check("batch_timeout", 32'(edges), 32'd28);
        edges = 0;
        while (res_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        if (res_valid) check("handshake_timeout", 32'(res_valid), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int edges;
        edges = 0;
        while (!res_valid && edges < budget) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!res_valid) check("valid_timeout", 32'(edges), 32'(budget - 1));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; run_len = 0; overlap = 0; seen_valid = 1'b0;
        rst_n = 1'b1; req = 1'b0; abort = 1'b0; res_ready = 1'b1; tdc_code = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clr", 32'(tdc_clr), 32'd0);
        check("rst_start", 32'(tdc_start), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_result", {res_count, res_mean, res_err}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // abort beats req in IDLE
        req = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; abort = 1'b0;
        check("abort_over_req", {29'd0, dbg_state}, 32'd0);
        check("abort_over_req_busy", 32'(busy), 32'd0);

        // T1
        win_q.delete();
        exp_q.push_back(pack(32, 8, 1'b0));
        run_batch(32'h0000_00FF, 32'h0000_00FF, lat);
        check("t1_latency", 32'(lat), 32'd28);
        check("t1_windows", 32'(win_q.size()), 32'd4);
        for (int i = 0; i < win_q.size() && i < 4; i++) check("t1_window_len", 32'(win_q[i]), 32'd5);

        // T2
        exp_q.push_back(pack(128, 32, 1'b0));
        run_batch(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("t2_latency", 32'(lat), 32'd28);
        exp_q.push_back(pack(0, 0, 1'b0));
        run_batch(32'h0, 32'h0, lat);

        // T3: stall in DONE with req held, then back-to-back batch
        tdc_code = 32'h0000_00FF;
        res_ready = 1'b0;
        req = 1'b1;
        exp_q.push_back(pack(32, 8, 1'b0));
        exp_q.push_back(pack(32, 8, 1'b0));
        wait_valid(100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t3_hold", {22'd0, res_valid, busy, res_count}, {22'd0, 1'b1, 1'b1, 8'd32});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_idle_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        check("t3_restart_clr", 32'(tdc_clr), 32'd1);
        check("t3_restart_busy", 32'(busy), 32'd1);
        wait_valid(100);
        @(posedge clk); #1;

        // T4: abort in SETTLE of the second sample
        tdc_code = 32'h0000_00FF;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t4_in_settle", {29'd0, dbg_state}, 32'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_idle", {29'd0, dbg_state}, 32'd0);
        check("t4_start_low", 32'(tdc_start), 32'd0);
        check("t4_busy_low", 32'(busy), 32'd0);
        check("t4_acc_cleared", 32'(res_count), 32'd0);
        seen_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t4_no_valid", 32'(seen_valid), 32'd0);
        exp_q.push_back(pack(16, 4, 1'b0));
        run_batch(32'h0000_000F, 32'h0000_000F, lat);

        // T5: asynchronous reset mid-SETTLE
        tdc_code = 32'h0000_00FF;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_start_before", 32'(tdc_start), 32'd1);
        #2 rst_n = 1'b1;
        #1;
        check("t5_async_start", 32'(tdc_start), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(pack(32, 8, 1'b0));
        run_batch(32'h0000_00FF, 32'h0000_00FF, lat);
        check("t5_latency", 32'(lat), 32'd28);

        // T6: one bubbled sample
        exp_q.push_back(pack(31, 7, BUBBLE_ERR));
        run_batch(32'h0000_00F7, 32'h0000_00FF, lat);

        // a clean batch after the bubbled one clears the flag
        exp_q.push_back(pack(128, 32, 1'b0));
        run_batch(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("clr_start_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
